// File: rtl/reg_file_arbiter_pkg.sv
// Shared definitions for the register-file arbiter: sizes, FSM encoding and
// the two-way round-robin pick rule.
package reg_file_arbiter_pkg;

    localparam int RF_AW = 4;
    localparam int RF_DW = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    // On a tie the port that did not win last time is chosen.
    function automatic logic rr_pick_id(input logic req0,
                                        input logic req1,
                                        input logic last_grant);
        logic id;
        if (req0 && req1) begin
            id = ~last_grant;
        end else if (req1) begin
            id = 1'b1;
        end else begin
            id = 1'b0;
        end
        return id;
    endfunction

endpackage

// File: rtl/reg_file_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker used by the register-file arbiter.
module rr_arb2
    import reg_file_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    // Grant decision from the current requests and the previous winner
    always_comb begin
        gnt_valid = req0 | req1;
        gnt_id    = rr_pick_id(req0, req1, last_grant);
    end

endmodule

// File: rtl/reg_file_arbiter.sv
// Shares one single-port register file between a core port (0) and a debug
// port (1): round-robin grant, one access per grant, registered outputs.
module reg_file_arbiter
    import reg_file_arbiter_pkg::*;
#(
    parameter int AW = RF_AW,
    parameter int DW = RF_DW
) (
    input  logic          clk,
    input  logic          CLB,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_wdata,
    output logic          rf_load,
    input  logic [DW-1:0] rf_rdata,
    output logic          busy
);

    state_e        state_r;
    state_e        state_nxt_s;
    logic          last_grant_r;
    logic          last_grant_nxt_s;
    logic          gnt_id_r;
    logic          gnt_id_nxt_s;
    logic          gnt_valid_s;
    logic          gnt_pick_s;
    logic [AW-1:0] rf_addr_nxt_s;
    logic [DW-1:0] rf_wdata_nxt_s;
    logic          rf_load_nxt_s;
    logic          ack0_nxt_s;
    logic          ack1_nxt_s;
    logic [DW-1:0] rdata0_nxt_s;
    logic [DW-1:0] rdata1_nxt_s;
    logic          busy_nxt_s;

    rr_arb2 u_rr_arb2 (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant_r),
        .gnt_valid  (gnt_valid_s),
        .gnt_id     (gnt_pick_s)
    );

    // Next-state and next-output logic; requests are only looked at in IDLE
    always_comb begin
        state_nxt_s      = state_r;
        last_grant_nxt_s = last_grant_r;
        gnt_id_nxt_s     = gnt_id_r;
        rf_addr_nxt_s    = rf_addr;
        rf_wdata_nxt_s   = rf_wdata;
        rf_load_nxt_s    = 1'b0;
        ack0_nxt_s       = 1'b0;
        ack1_nxt_s       = 1'b0;
        rdata0_nxt_s     = rdata0;
        rdata1_nxt_s     = rdata1;
        case (state_r)
            IDLE: begin
                if (gnt_valid_s) begin
                    state_nxt_s      = ACCESS;
                    gnt_id_nxt_s     = gnt_pick_s;
                    last_grant_nxt_s = gnt_pick_s;
                    if (gnt_pick_s) begin
                        rf_addr_nxt_s  = addr1;
                        rf_wdata_nxt_s = wdata1;
                        rf_load_nxt_s  = we1;
                    end else begin
                        rf_addr_nxt_s  = addr0;
                        rf_wdata_nxt_s = wdata0;
                        rf_load_nxt_s  = we0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCESS: begin
                state_nxt_s = DONE;
                // rf_load doubles as the stored write flag of the current grant
                if (!rf_load && gnt_id_r) begin
                    rdata1_nxt_s = rf_rdata;
                end else if (!rf_load) begin
                    rdata0_nxt_s = rf_rdata;
                end else begin
                    rdata0_nxt_s = rdata0;
                end
                if (gnt_id_r) begin
                    ack1_nxt_s = 1'b1;
                end else begin
                    ack0_nxt_s = 1'b1;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s      = IDLE;
                last_grant_nxt_s = 1'b1;
                gnt_id_nxt_s     = 1'b0;
                rf_addr_nxt_s    = {AW{1'b0}};
                rf_wdata_nxt_s   = {DW{1'b0}};
                rdata0_nxt_s     = {DW{1'b0}};
                rdata1_nxt_s     = {DW{1'b0}};
            end
        endcase
        busy_nxt_s = (state_nxt_s != IDLE);
    end

    // State and output registers; reset drops any access in flight
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            gnt_id_r     <= 1'b0;
            rf_addr      <= {AW{1'b0}};
            rf_wdata     <= {DW{1'b0}};
            rf_load      <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata0       <= {DW{1'b0}};
            rdata1       <= {DW{1'b0}};
            busy         <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            gnt_id_r     <= gnt_id_nxt_s;
            rf_addr      <= rf_addr_nxt_s;
            rf_wdata     <= rf_wdata_nxt_s;
            rf_load      <= rf_load_nxt_s;
            ack0         <= ack0_nxt_s;
            ack1         <= ack1_nxt_s;
            rdata0       <= rdata0_nxt_s;
            rdata1       <= rdata1_nxt_s;
            busy         <= busy_nxt_s;
        end
    end

endmodule

// File: tb/tb_reg_file_arbiter.sv
// Bench for reg_file_arbiter: register-file environment plus a transaction
// level model (pending requests, round-robin rule, 3-cycle service slot).
module tb_reg_file_arbiter;

    logic       clk;
    logic       CLB;
    logic       req0, we0, req1, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic [3:0] rf_addr;
    logic [7:0] rf_wdata;
    logic       rf_load;
    logic [7:0] rf_rdata;
    logic       busy;

    int tests = 0;
    int fails = 0;

    reg_file_arbiter dut (
        .clk(clk), .CLB(CLB),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1),
        .rf_addr(rf_addr), .rf_wdata(rf_wdata), .rf_load(rf_load),
        .rf_rdata(rf_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The register file the arbiter sits in front of
    logic [7:0] rf_mem [16];
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 8'h00;
        end else if (rf_load) begin
            rf_mem[rf_addr] <= rf_wdata;
        end
    end
    assign rf_rdata = rf_mem[rf_addr];

    // Reference model state
    logic [7:0] ref_mem [16];
    logic [7:0] model_rd [2];
    bit         pend [2];
    bit         pwe [2];
    logic [3:0] paddr [2];
    logic [7:0] pdat [2];
    int         cyc, ack_cyc, load_cyc, free_cyc;
    bit         cur_w, cur_we, last;
    logic [3:0] cur_addr;
    logic [7:0] cur_dat;
    int         order [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pins(input bit p);
        if (p) begin
            req1 = pend[1]; we1 = pwe[1]; addr1 = paddr[1]; wdata1 = pdat[1];
        end else begin
            req0 = pend[0]; we0 = pwe[0]; addr0 = paddr[0]; wdata0 = pdat[0];
        end
    endtask

    task automatic post(input bit p, input bit we, input logic [3:0] a, input logic [7:0] d);
        pend[p] = 1'b1; pwe[p] = we; paddr[p] = a; pdat[p] = d;
        set_pins(p);
    endtask

    // One clock: predict a grant for the coming edge, then check at the negedge
    task automatic tick();
        if (cyc >= free_cyc && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) cur_w = ~last;
            else                    cur_w = pend[1];
            last     = cur_w;
            cur_we   = pwe[cur_w];
            cur_addr = paddr[cur_w];
            cur_dat  = pdat[cur_w];
            load_cyc = cyc + 1;
            ack_cyc  = cyc + 2;
            free_cyc = cyc + 3;
            order.push_back(int'(cur_w));
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
        if (cyc == ack_cyc) begin
            if (cur_we) ref_mem[cur_addr] = cur_dat;
            else        model_rd[cur_w] = ref_mem[cur_addr];
            pend[cur_w] = 1'b0;
            set_pins(cur_w);
        end
        check("ack0", ack0, (cyc == ack_cyc && !cur_w));
        check("ack1", ack1, (cyc == ack_cyc && cur_w));
        check("rf_load", rf_load, (cyc == load_cyc && cur_we));
        check("busy", busy, (cyc == load_cyc || cyc == ack_cyc));
        check("rdata0", rdata0, model_rd[0]);
        check("rdata1", rdata1, model_rd[1]);
        if (cyc == load_cyc) begin
            check("rf_addr", rf_addr, cur_addr);
            check("rf_wdata", rf_wdata, cur_dat);
        end
    endtask

    task automatic run_until_idle(input int maxc, input string tag);
        int n = 0;
        while ((pend[0] || pend[1] || cyc < free_cyc) && n < maxc) begin
            tick();
            n++;
        end
        check({tag, "_done"}, (n < maxc), 1'b1);
    endtask

    // Entered at a negedge; asserts CLB there, checks the immediate reset state
    task automatic do_reset();
        CLB = 1'b0;
        #1;
        check("rst_ack0", ack0, 1'b0);
        check("rst_ack1", ack1, 1'b0);
        check("rst_load", rf_load, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_addr", rf_addr, 4'h0);
        check("rst_wdata", rf_wdata, 8'h00);
        check("rst_rdata0", rdata0, 8'h00);
        check("rst_rdata1", rdata1, 8'h00);
        for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
        for (int p = 0; p < 2; p++) begin
            model_rd[p] = 8'h00; pend[p] = 1'b0; pwe[p] = 1'b0;
            paddr[p] = 4'h0; pdat[p] = 8'h00;
        end
        set_pins(1'b0);
        set_pins(1'b1);
        last = 1'b1; cur_w = 1'b0; cur_we = 1'b0;
        ack_cyc = -100; load_cyc = -100;
        @(negedge clk);
        @(negedge clk);
        cyc += 2;
        CLB = 1'b1;
        free_cyc = cyc;
    endtask

    initial begin
        logic [31:0] r;
        cyc = 0;
        CLB = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = 4'h0; wdata0 = 8'h00;
        req1 = 1'b0; we1 = 1'b0; addr1 = 4'h0; wdata1 = 8'h00;
        @(negedge clk);
        do_reset();

        // Single port-0 write
        post(1'b0, 1'b1, 4'd3, 8'hA5);
        run_until_idle(10, "t1");

        // Port-1 read of the word just written, held after req drops
        post(1'b1, 1'b0, 4'd3, 8'h00);
        run_until_idle(10, "t2");
        check("t2_rdata1", rdata1, 8'hA5);
        tick(); tick();
        check("t2_hold", rdata1, 8'hA5);

        // Simultaneous requests just after reset
        do_reset();
        order.delete();
        post(1'b0, 1'b1, 4'd5, 8'h11);
        post(1'b1, 1'b0, 4'd5, 8'h00);
        run_until_idle(12, "t3");
        check("t3_first", order[0], 0);
        check("t3_second", order[1], 1);
        check("t3_rdata1", rdata1, 8'h11);

        // Both ports kept requesting: grants alternate
        order.delete();
        for (int n = 0; n < 40 && order.size() < 4; n++) begin
            r = $urandom;
            if (!pend[0]) post(1'b0, 1'b1, r[3:0], r[11:4]);
            if (!pend[1]) post(1'b1, 1'b0, r[15:12], 8'h00);
            tick();
        end
        run_until_idle(12, "t3b");
        check("t3_alt0", order[0], 0);
        check("t3_alt1", order[1], 1);
        check("t3_alt2", order[2], 0);
        check("t3_alt3", order[3], 1);

        // Reset during the ACCESS cycle of a port-1 write
        post(1'b1, 1'b1, 4'd7, 8'h3C);
        tick();
        do_reset();
        tick(); tick();
        post(1'b0, 1'b0, 4'd7, 8'h00);
        run_until_idle(10, "t4");
        check("t4_dropped_write", rdata0, 8'h00);

        // Address change while busy is ignored
        post(1'b1, 1'b1, 4'd2, 8'h5A);
        run_until_idle(10, "t5a");
        post(1'b1, 1'b1, 4'd9, 8'hC3);
        run_until_idle(10, "t5b");
        post(1'b0, 1'b0, 4'd2, 8'h00);
        tick();
        addr0 = 4'd9;
        run_until_idle(10, "t5");
        check("t5_rdata0", rdata0, 8'h5A);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            r = $urandom;
            if (!pend[0] && r[16]) post(1'b0, r[0], r[4:1], r[12:5]);
            r = $urandom;
            if (!pend[1] && r[16]) post(1'b1, r[0], r[4:1], r[12:5]);
            tick();
        end
        run_until_idle(20, "rand");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
